quicksort_main: RTL and testbench
=================================

Name: quicksort_main

Overview:
- HLS-style accelerator that sorts an on-chip array of 16 signed 8-bit elements into ascending order using an iterative quicksort.
- Control uses a start_port/done_port pulse handshake.
- The array is visible to a host through a 2-channel byte-wide slave memory port.
- A 2-channel master memory port exists for bus chaining; this configuration never drives it.

Parameters:
- MEM_var_28860_28869, 32: slave-space base byte address of the 16-byte data array.
- MEM_var_29141_28866, 32: base address of the internal partition stack. Not slave-decoded; kept for interface compatibility.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start_port  in  1  one-cycle start pulse
- S_oe_ram  in  2  slave read enable per channel
- S_we_ram  in  2  slave write enable per channel
- S_addr_ram  in  14  channel ch address = bits [7ch+6:7ch]
- S_Wdata_ram  in  16  channel ch write byte = bits [8ch+7:8ch]
- S_data_ram_size  in  8  channel ch access size in bits = [4ch+3:4ch]
- M_Rdata_ram  in  16  master read data (ignored)
- M_DataRdy  in  2  master ready (ignored)
- done_port  out  1  one-cycle completion pulse
- Sout_Rdata_ram  out  16  slave read data per channel
- Sout_DataRdy  out  2  slave access-complete per channel
- Mout_oe_ram, Mout_we_ram  out  2 each  master enables, constant 0
- Mout_addr_ram  out  14  constant 0
- Mout_Wdata_ram  out  16  constant 0
- Mout_data_ram_size  out  8  constant 0

Behaviour:
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The array is loaded with A[i] = ((7*i+46) mod 32) − 16 for i = 0..15, i.e. -2,5,12,-13,-6,1,8,15,-10,-3,4,11,-14,-7,0,7.
  - Reset mid-sort aborts the sort, suppresses done, and reloads this table.
- Handshake:
  - start_port high in IDLE starts a sort of the current array contents; start_port while busy is ignored.
  - done_port is high for exactly one cycle, at least 2 cycles after start, then the FSM returns to IDLE.
  - A 16-element sort completes within 2000 cycles.
- Algorithm (signed 8-bit compare):
  - Iterative quicksort with Lomuto partition, pivot = A[hi].
  - Explicit stack of (lo,hi) pairs, 4-bit indices, depth 16; push only ranges with lo<hi.
  - The initial push is (0,15).
  - A sort of an already sorted array leaves it unchanged.
- FSM states: IDLE, POP, PART_INIT, PART_CMP, PART_SWAP, PIVOT_SWAP, PUSH, DONE.
  - IDLE → POP on start.
  - POP → DONE on an empty stack, otherwise → PART_INIT.
  - PART_INIT → PART_CMP.
  - PART_CMP loops j = lo..hi−1, going to PART_SWAP when A[j] < pivot.
  - PART_SWAP returns to PART_CMP.
  - After j = hi−1, PART_CMP → PIVOT_SWAP (swap A[i] and A[hi]) → PUSH.
  - PUSH pushes (lo,p−1) and (p+1,hi) → POP.
  - DONE → IDLE.
- Slave port, per channel ch independently:
  - An access hits when MEM_var_28860_28869 ≤ addr < MEM_var_28860_28869+16; offset = addr − base.
  - Read (oe=1, hit): the byte appears on Sout_Rdata_ram channel bits the next cycle, with Sout_DataRdy[ch]=1 that cycle.
  - Write (we=1, hit): new = (wdata & mask) | (old & ~mask), where mask = (1<<size)−1 truncated to 8 bits. It takes effect at the clock edge; Sout_DataRdy[ch]=1 the next cycle.
  - Writes are ignored while not IDLE, but still complete with DataRdy. Reads are always serviced.
  - Non-hit accesses give Sout_Rdata 0 and DataRdy 0.
  - Sout_Rdata is 0 whenever no read response is due, because the host ORs it with other sources.
  - Channels 0 and 1 writing the same offset in the same cycle: channel 1 wins.
  - oe and we both high on one channel is illegal; treat it as a read.
- No combinational path from any S_* input to any Mout_* output; the host loops Mout back to S.

Decomposition:
- Package quicksort_pkg: N=16, ELEM_W=8, IDX_W=4, ADDR_W=7, STACK_DEPTH=16, the reset-contents table, and the FSM state enum.
- Sub-module quicksort_array_ram holds the 16x8 register array. It provides:
  - one sorter read/write port (two combinational reads for swap, two writes);
  - the two slave channels with masked write and 1-cycle read register;
  - synchronous reload on reset.

Test Plan:
- Reset 2 cycles, pulse start → done pulses once within 2000 cycles; Mout_* stay 0 throughout.
- After the first sort, read addresses 32..47 on both channels → -14,-13,-10,-7,-6,-3,-2,0,1,4,5,7,8,11,12,15, each with DataRdy one cycle after the request.
- Write 15,14,...,0 to addresses 32..47 (size 8), start → read back 0..15; start again → unchanged 0..15, done again.
- Write all 5 then start → all 5. Write to address 31 or 48 → DataRdy 0, Rdata 0, array untouched.
- Assert reset 50 cycles after start → no done; array reads back the reset table; a new start then sorts correctly.
- Same-cycle writes on ch0 and ch1 to address 40 (0x11, 0x22) → reads 0x22. A write with size 4 of 0xFF over 0x00 → 0x0F.

Source files
------------

// File: rtl/quicksort_pkg.sv
// rtl/quicksort_pkg.sv - sizes, reset contents and FSM states for the quicksort accelerator
package quicksort_pkg;

  localparam int N           = 16;
  localparam int ELEM_W      = 8;
  localparam int IDX_W       = 4;
  localparam int ADDR_W      = 7;
  localparam int STACK_DEPTH = 16;
  localparam int SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int SIDX_W      = $clog2(STACK_DEPTH);
  localparam int NCH         = 2;
  localparam int SIZE_W      = 4;

  typedef enum logic [2:0] {
    IDLE, POP, PART_INIT, PART_CMP, PART_SWAP, PIVOT_SWAP, PUSH, DONE
  } state_e;

  function automatic logic [ELEM_W-1:0] reset_elem(input int i);
    return ELEM_W'(((7 * i + 46) % 32) - 16);
  endfunction

endpackage

// File: rtl/quicksort_array_ram.sv
// rtl/quicksort_array_ram.sv - 16x8 register array with a sorter swap port and two host byte channels
module quicksort_array_ram
  import quicksort_pkg::*;
#(
  parameter int unsigned BASE = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_W-1:0]         rd_idx_a,
  input  logic [IDX_W-1:0]         rd_idx_b,
  output logic [ELEM_W-1:0]        rd_data_a,
  output logic [ELEM_W-1:0]        rd_data_b,
  input  logic                     swap_en,
  input  logic [IDX_W-1:0]         wr_idx_a,
  input  logic [IDX_W-1:0]         wr_idx_b,
  input  logic [ELEM_W-1:0]        wr_data_a,
  input  logic [ELEM_W-1:0]        wr_data_b,
  input  logic                     host_wr_en,
  input  logic [NCH-1:0]           s_oe,
  input  logic [NCH-1:0]           s_we,
  input  logic [NCH*ADDR_W-1:0]    s_addr,
  input  logic [NCH*ELEM_W-1:0]    s_wdata,
  input  logic [NCH*SIZE_W-1:0]    s_size,
  output logic [NCH*ELEM_W-1:0]    s_rdata,
  output logic [NCH-1:0]           s_rdy
);

  logic [ELEM_W-1:0]     mem_q [N];
  logic [ELEM_W-1:0]     mem_d [N];
  logic [NCH*ELEM_W-1:0] rdata_q, rdata_d;
  logic [NCH-1:0]        rdy_q, rdy_d;
  logic [NCH-1:0]        hit;
  logic [IDX_W-1:0]      off  [NCH];
  logic [ELEM_W-1:0]     mask [NCH];

  for (genvar ch = 0; ch < NCH; ch++) begin : g_dec
    logic [31:0] addr;
    assign addr     = 32'(s_addr[ch*ADDR_W +: ADDR_W]);
    assign hit[ch]  = (addr >= BASE) && (addr < BASE + 32'(N));
    assign off[ch]  = IDX_W'(addr - BASE);
    assign mask[ch] = ELEM_W'((16'd1 << s_size[ch*SIZE_W +: SIZE_W]) - 16'd1);
  end

  always_comb begin
    mem_d   = mem_q;
    rdata_d = '0;
    rdy_d   = '0;
    if (swap_en) begin
      mem_d[wr_idx_a] = wr_data_a;
      mem_d[wr_idx_b] = wr_data_b;
    end
    // Channel 1 is applied last so it wins a same-offset write collision.
    for (int ch = 0; ch < NCH; ch++) begin
      if (hit[ch] && s_oe[ch]) begin
        rdata_d[ch*ELEM_W +: ELEM_W] = mem_q[off[ch]];
        rdy_d[ch]                    = 1'b1;
      end else if (hit[ch] && s_we[ch]) begin
        rdy_d[ch] = 1'b1;
        if (host_wr_en) begin
          mem_d[off[ch]] = (s_wdata[ch*ELEM_W +: ELEM_W] & mask[ch]) |
                           (mem_q[off[ch]] & ~mask[ch]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= reset_elem(i);
      rdata_q <= '0;
      rdy_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rd_data_a = mem_q[rd_idx_a];
  assign rd_data_b = mem_q[rd_idx_b];
  assign s_rdata   = rdata_q;
  assign s_rdy     = rdy_q;

endmodule

// File: rtl/quicksort_main.sv
// rtl/quicksort_main.sv - iterative Lomuto quicksort over a host-visible 16-byte array
module quicksort_main
  import quicksort_pkg::*;
#(
  parameter int unsigned MEM_var_28860_28869 = 32,
  parameter int unsigned MEM_var_29141_28866 = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [13:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [13:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         lo_q, lo_d, hi_q, hi_d, j_q, j_d, s_q, s_d;
  logic signed [ELEM_W-1:0] pivot_q, pivot_d;
  logic [SP_W-1:0]          sp_q, sp_d, push_sp;
  logic [IDX_W-1:0]         stk_lo_q [STACK_DEPTH];
  logic [IDX_W-1:0]         stk_lo_d [STACK_DEPTH];
  logic [IDX_W-1:0]         stk_hi_q [STACK_DEPTH];
  logic [IDX_W-1:0]         stk_hi_d [STACK_DEPTH];
  logic                     done_q, done_d;

  logic [IDX_W-1:0]  rd_idx_a, rd_idx_b;
  logic [ELEM_W-1:0] rd_data_a, rd_data_b;
  logic              swap_en;
  logic              unused_ok;

  assign unused_ok = ^{M_Rdata_ram, M_DataRdy, MEM_var_29141_28866};

  quicksort_array_ram #(
    .BASE (MEM_var_28860_28869)
  ) u_ram (
    .clk        (clock),
    .rst        (reset),
    .rd_idx_a   (rd_idx_a),
    .rd_idx_b   (rd_idx_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .swap_en    (swap_en),
    .wr_idx_a   (rd_idx_a),
    .wr_idx_b   (rd_idx_b),
    .wr_data_a  (rd_data_b),
    .wr_data_b  (rd_data_a),
    .host_wr_en (state_q == IDLE),
    .s_oe       (S_oe_ram),
    .s_we       (S_we_ram),
    .s_addr     (S_addr_ram),
    .s_wdata    (S_Wdata_ram),
    .s_size     (S_data_ram_size),
    .s_rdata    (Sout_Rdata_ram),
    .s_rdy      (Sout_DataRdy)
  );

  // Both swaps exchange the two read ports' elements crosswise.
  always_comb begin
    rd_idx_a = j_q;
    rd_idx_b = hi_q;
    swap_en  = 1'b0;
    case (state_q)
      PART_SWAP: begin
        rd_idx_a = s_q;
        rd_idx_b = j_q;
        swap_en  = 1'b1;
      end
      PIVOT_SWAP: begin
        rd_idx_a = s_q;
        swap_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    j_d      = j_q;
    s_d      = s_q;
    pivot_d  = pivot_q;
    sp_d     = sp_q;
    stk_lo_d = stk_lo_q;
    stk_hi_d = stk_hi_q;
    done_d   = 1'b0;
    push_sp  = sp_q;
    case (state_q)
      IDLE: begin
        if (start_port) begin
          stk_lo_d[0] = '0;
          stk_hi_d[0] = IDX_W'(N - 1);
          sp_d        = SP_W'(1);
          state_d     = POP;
        end
      end
      POP: begin
        if (sp_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          lo_d    = stk_lo_q[SIDX_W'(sp_q - 1'b1)];
          hi_d    = stk_hi_q[SIDX_W'(sp_q - 1'b1)];
          sp_d    = sp_q - 1'b1;
          state_d = PART_INIT;
        end
      end
      PART_INIT: begin
        pivot_d = rd_data_b;
        j_d     = lo_q;
        s_d     = lo_q;
        state_d = PART_CMP;
      end
      PART_CMP: begin
        if (j_q == hi_q) begin
          state_d = PIVOT_SWAP;
        end else if ($signed(rd_data_a) < pivot_q) begin
          state_d = PART_SWAP;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      PART_SWAP: begin
        s_d     = s_q + 1'b1;
        j_d     = j_q + 1'b1;
        state_d = PART_CMP;
      end
      PIVOT_SWAP: state_d = PUSH;
      PUSH: begin
        // Pivot landed at s; 5-bit compares keep s-1 / s+1 from wrapping.
        if ({1'b0, s_q} > {1'b0, lo_q} + 5'd1) begin
          stk_lo_d[SIDX_W'(push_sp)] = lo_q;
          stk_hi_d[SIDX_W'(push_sp)] = s_q - 1'b1;
          push_sp                    = push_sp + 1'b1;
        end
        if ({1'b0, s_q} + 5'd1 < {1'b0, hi_q}) begin
          stk_lo_d[SIDX_W'(push_sp)] = s_q + 1'b1;
          stk_hi_d[SIDX_W'(push_sp)] = hi_q;
          push_sp                    = push_sp + 1'b1;
        end
        sp_d    = push_sp;
        state_d = POP;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      j_q     <= '0;
      s_q     <= '0;
      pivot_q <= '0;
      sp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      j_q     <= j_d;
      s_q     <= s_d;
      pivot_q <= pivot_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    stk_lo_q <= stk_lo_d;
    stk_hi_q <= stk_hi_d;
  end

  assign done_port          = done_q;
  assign Mout_oe_ram        = '0;
  assign Mout_we_ram        = '0;
  assign Mout_addr_ram      = '0;
  assign Mout_Wdata_ram     = '0;
  assign Mout_data_ram_size = '0;

endmodule

// File: tb/tb_quicksort_main.sv
// tb/tb_quicksort_main.sv - scoreboard bench for the quicksort accelerator
module tb_quicksort_main;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_port;
  logic [1:0]  S_oe_ram, S_we_ram;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram;
  logic [7:0]  S_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        done_port;
  logic [15:0] Sout_Rdata_ram;
  logic [1:0]  Sout_DataRdy;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;

  always #5 clock = ~clock;

  quicksort_main #(
    .MEM_var_28860_28869 (32),
    .MEM_var_29141_28866 (32)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .start_port         (start_port),
    .S_oe_ram           (S_oe_ram),
    .S_we_ram           (S_we_ram),
    .S_addr_ram         (S_addr_ram),
    .S_Wdata_ram        (S_Wdata_ram),
    .S_data_ram_size    (S_data_ram_size),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .done_port          (done_port),
    .Sout_Rdata_ram     (Sout_Rdata_ram),
    .Sout_DataRdy       (Sout_DataRdy),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size)
  );

  typedef struct {
    int         due;
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t              sb[$];
  logic signed [7:0] model [16];
  int                rst_tab [16] = '{-2, 5, 12, -13, -6, 1, 8, 15, -10, -3, 4, 11, -14, -7, 0, 7};
  int                cyc = 0;
  int                tests_run = 0;
  int                tests_failed = 0;
  bit                mon_en = 1'b0;
  bit                tb_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Every cycle: slave responses must match the scoreboard (zero when nothing is due), master stays silent.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [15:0] exp_data;
      logic [1:0]  exp_rdy;
      exp_t        e;
      exp_data = '0;
      exp_rdy  = '0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        exp_rdy[e.ch]          = 1'b1;
        exp_data[e.ch*8 +: 8]  = e.data;
      end
      tests_run++;
      if (Sout_DataRdy !== exp_rdy || Sout_Rdata_ram !== exp_data) begin
        tests_failed++;
        $display("FAIL slave_resp cyc=%0d: got rdy=%b rdata=%h, expected rdy=%b rdata=%h",
                 cyc, Sout_DataRdy, Sout_Rdata_ram, exp_rdy, exp_data);
      end
      tests_run++;
      if ({Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size} !== 58'd0) begin
        tests_failed++;
        $display("FAIL mout_zero cyc=%0d: got oe=%b we=%b addr=%h wdata=%h size=%h, expected all 0",
                 cyc, Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic host_cycle(input logic [1:0] oe, input logic [1:0] we,
                            input logic [6:0] a0, input logic [6:0] a1,
                            input logic [7:0] w0, input logic [7:0] w1,
                            input logic [3:0] z0, input logic [3:0] z1);
    logic [6:0]        a [2];
    logic [7:0]        w [2];
    logic [3:0]        z [2];
    logic [7:0]        m;
    int                off;
    exp_t              e;
    logic signed [7:0] nxt [16];
    a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1; z[0] = z0; z[1] = z1;
    S_oe_ram        = oe;
    S_we_ram        = we;
    S_addr_ram      = {a1, a0};
    S_Wdata_ram     = {w1, w0};
    S_data_ram_size = {z1, z0};
    nxt = model;
    for (int ch = 0; ch < 2; ch++) begin
      off = int'(a[ch]) - 32;
      if (off >= 0 && off < 16) begin
        if (oe[ch]) begin
          e.due = cyc + 1; e.ch = ch; e.data = model[off];
          sb.push_back(e);
        end else if (we[ch]) begin
          e.due = cyc + 1; e.ch = ch; e.data = 8'h00;
          sb.push_back(e);
          if (!tb_busy) begin
            m = (z[ch] >= 4'd8) ? 8'hFF : 8'((1 << z[ch]) - 1);
            nxt[off] = (w[ch] & m) | (model[off] & ~m);
          end
        end
      end
    end
    model = nxt;
    tick;
    S_oe_ram = '0;
    S_we_ram = '0;
  endtask

  task automatic read_array;
    for (int i = 0; i < 16; i++) host_cycle(2'b11, 2'b00, 7'(32 + i), 7'(47 - i), 8'h0, 8'h0, 4'd0, 4'd0);
    tick;
  endtask

  task automatic write_array(input int v [16]);
    for (int k = 0; k < 8; k++)
      host_cycle(2'b00, 2'b11, 7'(32 + 2*k), 7'(33 + 2*k), 8'(v[2*k]), 8'(v[2*k+1]), 4'd8, 4'd8);
  endtask

  task automatic sort_model;
    logic signed [7:0] t;
    int                j;
    for (int i = 1; i < 16; i++) begin
      t = model[i];
      j = i - 1;
      while (j >= 0 && model[j] > t) begin
        model[j+1] = model[j];
        j--;
      end
      model[j+1] = t;
    end
  endtask

  task automatic run_sort(input bit busy_wr, output int lat, output int pulses);
    tb_busy    = 1'b1;
    start_port = 1'b1;
    tick;
    start_port = 1'b0;
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= 2000; k++) begin
      if (done_port === 1'b1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k >= lat + 4) break;
      if (busy_wr && k == 5) host_cycle(2'b00, 2'b01, 7'd32, 7'd0, 8'h55, 8'h00, 4'd8, 4'd0);
      else tick;
    end
    tb_busy = 1'b0;
    sort_model;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests_run++;
    if (done_port !== 1'b0 || Sout_DataRdy !== 2'b00 || Sout_Rdata_ram !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got done=%b rdy=%b rdata=%h, expected 0 0 0",
               done_port, Sout_DataRdy, Sout_Rdata_ram);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'(rst_tab[i]);
    mon_en = 1'b1;
    read_array;
  endtask

  task automatic test_first_sort;
    int lat, pulses;
    run_sort(1'b1, lat, pulses);
    tests_run++;
    if (pulses != 1 || lat < 2) begin
      tests_failed++;
      $display("FAIL first_sort_done: got pulses=%0d latency=%0d, expected 1 pulse at latency>=2", pulses, lat);
    end
    read_array;
  endtask

  task automatic test_reverse_sort;
    int lat, pulses;
    int v [16];
    for (int i = 0; i < 16; i++) v[i] = 15 - i;
    write_array(v);
    for (int pass = 0; pass < 2; pass++) begin
      run_sort(1'b0, lat, pulses);
      tests_run++;
      if (pulses != 1 || lat < 2) begin
        tests_failed++;
        $display("FAIL reverse_sort_done pass=%0d: got pulses=%0d latency=%0d, expected 1 pulse", pass, pulses, lat);
      end
      read_array;
    end
    host_cycle(2'b11, 2'b00, 7'd32, 7'd47, 8'h0, 8'h0, 4'd0, 4'd0);
    tests_run++;
    if (Sout_Rdata_ram !== 16'h0F00) begin
      tests_failed++;
      $display("FAIL reverse_sort_ends: got %h, expected 0f00", Sout_Rdata_ram);
    end
    tick;
  endtask

  task automatic test_all_five;
    int lat, pulses;
    int v [16];
    for (int i = 0; i < 16; i++) v[i] = 5;
    write_array(v);
    host_cycle(2'b00, 2'b11, 7'd31, 7'd48, 8'h7E, 8'h7E, 4'd8, 4'd8);
    host_cycle(2'b11, 2'b00, 7'd31, 7'd48, 8'h00, 8'h00, 4'd0, 4'd0);
    tests_run++;
    if (Sout_DataRdy !== 2'b00 || Sout_Rdata_ram !== 16'h0) begin
      tests_failed++;
      $display("FAIL out_of_range: got rdy=%b rdata=%h, expected 00 0000", Sout_DataRdy, Sout_Rdata_ram);
    end
    run_sort(1'b0, lat, pulses);
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL all_five_done: got pulses=%0d, expected 1", pulses);
    end
    read_array;
  endtask

  task automatic test_reset_mid_sort;
    int lat, pulses, seen;
    int v [16];
    for (int i = 0; i < 16; i++) v[i] = 15 - i;
    write_array(v);
    tb_busy    = 1'b1;
    start_port = 1'b1;
    tick;
    start_port = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (done_port === 1'b1) seen++;
      tick;
    end
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_port !== 1'b0) seen++;
      tick;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_abort_done: got %0d done cycles, expected 0", seen);
    end
    tb_busy = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'(rst_tab[i]);
    read_array;
    run_sort(1'b0, lat, pulses);
    tests_run++;
    if (pulses != 1 || lat < 2) begin
      tests_failed++;
      $display("FAIL resort_done: got pulses=%0d latency=%0d, expected 1 pulse", pulses, lat);
    end
    read_array;
  endtask

  task automatic test_same_cycle_write;
    host_cycle(2'b00, 2'b11, 7'd40, 7'd40, 8'h11, 8'h22, 4'd8, 4'd8);
    host_cycle(2'b00, 2'b01, 7'd41, 7'd0, 8'h00, 8'h00, 4'd8, 4'd0);
    host_cycle(2'b00, 2'b01, 7'd41, 7'd0, 8'hFF, 8'h00, 4'd4, 4'd0);
    host_cycle(2'b00, 2'b01, 7'd41, 7'd0, 8'hFF, 8'h00, 4'd0, 4'd0);
    host_cycle(2'b10, 2'b10, 7'd0, 7'd42, 8'h00, 8'h77, 4'd0, 4'd8);
    host_cycle(2'b11, 2'b00, 7'd40, 7'd41, 8'h00, 8'h00, 4'd0, 4'd0);
    tests_run++;
    if (Sout_Rdata_ram !== 16'h0F22 || Sout_DataRdy !== 2'b11) begin
      tests_failed++;
      $display("FAIL collision_mask: got rdy=%b rdata=%h, expected 11 0f22", Sout_DataRdy, Sout_Rdata_ram);
    end
    read_array;
  endtask

  initial begin
    reset           = 1'b1;
    start_port      = 1'b0;
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    M_Rdata_ram     = 16'hA5A5;
    M_DataRdy       = 2'b11;
    test_reset;
    test_first_sort;
    test_reverse_sort;
    test_all_five;
    test_reset_mid_sort;
    test_same_cycle_write;
    tick;
    tick;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
